// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 7-segment display blocks: segment bit order,
// off-state constants, the active-low hex font and the display data word.
package seg7_scan_driver_pkg;

  localparam int unsigned SEG_DP = 7;
  localparam int unsigned SEG_CA = 0;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low {G..A} patterns; entry 0 sits in the least significant slot.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
  } disp_word_t;

endpackage

// File: rtl/seg7_hex_font.sv
// Combinational hex nibble to active-low 7-segment pattern {G..A}.
module seg7_hex_font
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = HEX_FONT[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode display driver with a double-buffered
// data path; staged updates commit only at the frame boundary.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [31:0] DATA,
  input  logic [7:0]  DP_IN,
  input  logic [7:0]  EN_IN,
  input  logic        LOAD,
  output logic        LOAD_ACK,
  output logic        BUSY,
  output logic [7:0]  SEG,
  output logic [7:0]  AN
);

  localparam int unsigned PERIOD = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned BLK_W  = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [BLK_W-1:0] BLK_INIT = BLK_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [BLK_W-1:0] blank;
  logic             tick;
  logic             commit;
  logic             pending;
  logic             ack_q;
  disp_word_t       incoming;
  disp_word_t       stage;
  disp_word_t       shadow;
  logic [3:0]       nibble;
  logic [6:0]       font_seg;
  logic             digit_on;
  logic [7:0]       seg_next;
  logic [7:0]       an_next;
  logic [7:0]       seg_q;
  logic [7:0]       an_q;

  always_comb begin
    tick     = (cnt == CNT_LAST);
    commit   = tick && (idx == 3'd7) && (pending || LOAD);
    incoming = {DATA, DP_IN, EN_IN};
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt   <= '0;
      idx   <= '0;
      blank <= BLK_INIT;
    end else begin
      if (tick) begin
        cnt   <= '0;
        idx   <= idx + 3'd1;
        blank <= BLK_INIT;
      end else begin
        cnt <= cnt + 1'b1;
        if (blank != '0) blank <= blank - 1'b1;
      end
    end
  end

  // A LOAD landing on the committing tick goes straight to the shadow copy.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      stage   <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= commit;
      if (LOAD) stage <= incoming;
      if (commit) begin
        shadow  <= LOAD ? incoming : stage;
        pending <= 1'b0;
      end else if (LOAD) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    nibble = shadow.data[{idx, 2'b00} +: 4];
  end

  seg7_hex_font u_font (
    .nibble (nibble),
    .seg_n  (font_seg)
  );

  always_comb begin
    digit_on = (blank == '0) && shadow.en[idx];
    seg_next = SEG_OFF;
    an_next  = AN_OFF;
    if (digit_on) begin
      an_next                  = ~(8'b1 << idx);
      seg_next[SEG_DP]         = ~shadow.dp[idx];
      seg_next[SEG_DP-1:SEG_CA] = font_seg;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= seg_next;
      an_q  <= an_next;
    end
  end

  always_comb begin
    SEG      = seg_q;
    AN       = an_q;
    LOAD_ACK = ack_q;
    BUSY     = pending;
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver against a frame/slot-level model.
module tb_seg7_scan_driver;

  localparam int unsigned CLK_HZ  = 800;
  localparam int unsigned SCAN_HZ = 100;
  localparam int unsigned BLANK   = 2;
  localparam int unsigned PERIOD  = CLK_HZ / SCAN_HZ;
  localparam int unsigned FRAME   = PERIOD * 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  en_in = '0;
  logic        load = 1'b0;
  logic        load_ack;
  logic        busy;
  logic [7:0]  seg;
  logic [7:0]  an;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .CLK_HZ       (CLK_HZ),
    .SCAN_HZ      (SCAN_HZ),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .DATA       (data),
    .DP_IN      (dp_in),
    .EN_IN      (en_in),
    .LOAD       (load),
    .LOAD_ACK   (load_ack),
    .BUSY       (busy),
    .SEG        (seg),
    .AN         (an)
  );

  logic [6:0] font_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: t = clock edges since reset release; position derives from t.
  int unsigned t;
  bit          pend;
  logic [31:0] st_d, sh_d;
  logic [7:0]  st_dp, sh_dp, st_en, sh_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; pend = 0;
    st_d = '0; st_dp = '0; st_en = '0;
    sh_d = '0; sh_dp = '0; sh_en = '0;
  endtask

  task automatic step(input logic ld, input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    int unsigned pos, dig;
    logic [3:0]  nib;
    logic [7:0]  exp_an, exp_seg;
    logic        exp_ack;
    load = ld; data = d; dp_in = p; en_in = e;
    pos = t % PERIOD;
    dig = (t / PERIOD) % 8;
    exp_an = 8'hFF; exp_seg = 8'hFF;
    if (pos >= BLANK && sh_en[dig]) begin
      nib     = sh_d[dig*4 +: 4];
      exp_an  = ~(8'd1 << dig);
      exp_seg = {~sh_dp[dig], font_tab[nib]};
    end
    exp_ack = 1'b0;
    if ((t % FRAME) == FRAME - 1 && (pend || ld)) begin
      exp_ack = 1'b1;
      if (ld) begin sh_d = d; sh_dp = p; sh_en = e; end
      else begin sh_d = st_d; sh_dp = st_dp; sh_en = st_en; end
      pend = 0;
    end else if (ld) begin
      st_d = d; st_dp = p; st_en = e; pend = 1;
    end
    t++;
    @(posedge clk); #1;
    check("AN", 32'(an), 32'(exp_an));
    check("SEG", 32'(seg), 32'(exp_seg));
    check("LOAD_ACK", 32'(load_ack), 32'(exp_ack));
    check("BUSY", 32'(busy), 32'(pend));
    load = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, $urandom, 8'($urandom), 8'($urandom));
  endtask

  task automatic run_to(input int unsigned frame_pos);
    for (int unsigned i = 0; i < FRAME && (t % FRAME) != frame_pos; i++) idle(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check("rst_AN", 32'(an), 32'hFF);
    check("rst_SEG", 32'(seg), 32'hFF);
    check("rst_ACK", 32'(load_ack), 32'h0);
    check("rst_BUSY", 32'(busy), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    idle(2 * FRAME);

    step(1'b1, 32'h76543210, 8'h00, 8'hFF);
    run_to(0); idle(FRAME);
    step(1'b1, 32'hFEDCBA98, 8'h00, 8'hFF);
    run_to(0); idle(FRAME);

    step(1'b1, 32'h89ABCDEF, 8'b0000_0100, 8'b0000_0101);
    run_to(0); idle(FRAME);

    // Mid-frame load: old data must survive digits 3..7.
    run_to(3 * PERIOD);
    step(1'b1, 32'h13579BDF, 8'hA5, 8'hFF);
    run_to(0); idle(FRAME);

    run_to(PERIOD);
    step(1'b1, 32'h11111111, 8'h00, 8'hFF);
    run_to(4 * PERIOD);
    step(1'b1, 32'h22222222, 8'h00, 8'hFF);
    run_to(0); idle(FRAME);

    // Load coinciding with the committing tick.
    run_to(FRAME - 1);
    step(1'b1, 32'h0F0F0F0F, 8'h0F, 8'hFF);
    idle(FRAME);

    for (int unsigned i = 0; i < 2 * FRAME; i++) step(1'b1, $urandom, 8'($urandom), 8'($urandom));

    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) step(1'b1, $urandom, 8'($urandom), 8'($urandom));
      else idle(1);
    end

    // Asynchronous reset mid-slot with an update pending.
    step(1'b1, 32'h44444444, 8'h00, 8'hFF);
    run_to(0);
    run_to(3 * PERIOD + 4);
    step(1'b1, 32'h55555555, 8'h00, 8'hFF);
    check("pre_rst_BUSY", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_AN", 32'(an), 32'hFF);
    check("arst_SEG", 32'(seg), 32'hFF);
    check("arst_BUSY", 32'(busy), 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle(2 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
